// File: rtl/cache_data_bank.sv
// ---------------------------------------------------------------------------
// cache_data_bank
//
// Data array of a cache. There is one write port with byte enables and one
// read port with a single cycle of latency. The read port returns the
// addressed word and also the whole line that holds it. A refill engine
// writes a line one beat at a time. The first beat lands on the critical
// word, and the word offset wraps around inside the line.
//
// The storage is split into LINE_WORDS banks. Bank gi holds word offset gi
// of every line. This lets a single access read a whole line, and lets the
// zero-fill after reset write a whole line, in one cycle.
//
// Ports
//   clk, resetn          clock (rising edge), async active-low reset
//   rd_req/rd_addr       read request / word address
//   rd_ready             read may be accepted this cycle
//   rd_valid             read data valid (one cycle after acceptance)
//   rd_data/rd_line      addressed word / its full line (word 0 in LSBs)
//   st_en/st_addr/...    byte-masked store, accepted only in IDLE
//   st_ready             store may be accepted
//   rf_start/rf_line/    start refill of a line, first word offset
//   rf_first
//   rf_beat_*            refill beat handshake and data
//   rf_done              one-cycle pulse when a refilled line is complete
//   busy                 controller is not in IDLE
// ---------------------------------------------------------------------------
module cache_data_bank #(
    parameter int ADDR_WIDTH    = 10,
    parameter int LINE_WORDS    = 8,
    parameter bit CLEAR_ON_INIT = 1'b0,
    parameter bit ENABLE_BYPASS = 1'b1,
    localparam int OFF          = $clog2(LINE_WORDS),
    localparam int LINE_IDX_W   = ADDR_WIDTH - OFF
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     rd_req,
    input  logic [ADDR_WIDTH-1:0]    rd_addr,
    output logic                     rd_ready,
    output logic                     rd_valid,
    output logic [31:0]              rd_data,
    output logic [32*LINE_WORDS-1:0] rd_line,
    input  logic                     st_en,
    input  logic [ADDR_WIDTH-1:0]    st_addr,
    input  logic [31:0]              st_data,
    input  logic [3:0]               st_ben,
    output logic                     st_ready,
    input  logic                     rf_start,
    input  logic [LINE_IDX_W-1:0]    rf_line,
    input  logic [OFF-1:0]           rf_first,
    input  logic                     rf_beat_valid,
    input  logic [31:0]              rf_beat_data,
    output logic                     rf_beat_ready,
    output logic                     rf_done,
    output logic                     busy
);

    localparam int NUM_LINES = 1 << LINE_IDX_W;

    localparam logic [1:0] S_CLEAR = 2'd0;
    localparam logic [1:0] S_IDLE  = 2'd1;
    localparam logic [1:0] S_FILL  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;
    localparam logic [1:0] S_RESET = CLEAR_ON_INIT ? S_CLEAR : S_IDLE;

    logic [1:0]            r_state;
    logic [1:0]            w_state_next;
    logic [OFF-1:0]        r_cnt;        // beats accepted in current refill
    logic [LINE_IDX_W-1:0] r_line;       // line being refilled
    logic [OFF-1:0]        r_first;      // critical word offset
    logic [LINE_IDX_W-1:0] r_clr_line;   // next line to zero-fill
    logic                  r_data_ok;    // a read has completed since reset
    logic [OFF-1:0]        r_rd_off;     // offset of last accepted read

    logic [LINE_IDX_W-1:0] w_rd_idx;
    logic [OFF-1:0]        w_rd_off;
    logic [LINE_IDX_W-1:0] w_st_idx;
    logic [OFF-1:0]        w_st_off;
    logic [OFF-1:0]        w_beat_off;
    logic                  w_rd_acc;
    logic                  w_st_acc;
    logic                  w_beat_acc;
    logic                  w_clear_wr;
    logic [LINE_IDX_W-1:0] w_wr_idx;
    logic [31:0]           w_wr_data;
    logic [3:0]            w_wr_ben;
    logic [LINE_WORDS-1:0] w_bank_we;

    assign w_rd_idx   = rd_addr[ADDR_WIDTH-1:OFF];
    assign w_rd_off   = rd_addr[OFF-1:0];
    assign w_st_idx   = st_addr[ADDR_WIDTH-1:OFF];
    assign w_st_off   = st_addr[OFF-1:0];
    // Wrap-around: the sum is truncated to the offset width.
    assign w_beat_off = r_first + r_cnt;

    assign st_ready      = (r_state == S_IDLE);
    assign rf_beat_ready = (r_state == S_FILL);
    assign rf_done       = (r_state == S_DONE);
    assign busy          = (r_state != S_IDLE);

    // While a line is being refilled, reads of that line are blocked. Reads
    // of every other line keep flowing.
    always_comb begin
        rd_ready = 1'b1;
        if (r_state == S_CLEAR) begin
            rd_ready = 1'b0;
        end else if ((r_state == S_FILL || r_state == S_DONE) && (w_rd_idx == r_line)) begin
            rd_ready = 1'b0;
        end
    end

    assign w_rd_acc   = rd_req & rd_ready;
    assign w_st_acc   = st_en & st_ready;
    assign w_beat_acc = rf_beat_valid & rf_beat_ready;
    assign w_clear_wr = (r_state == S_CLEAR);

    // Only one of the three writers is active at a time, and which one is
    // chosen by the state alone.
    always_comb begin
        w_wr_idx  = w_st_idx;
        w_wr_data = st_data;
        w_wr_ben  = st_ben;
        if (r_state == S_CLEAR) begin
            w_wr_idx  = r_clr_line;
            w_wr_data = 32'h0;
            w_wr_ben  = 4'hF;
        end else if (r_state == S_FILL) begin
            w_wr_idx  = r_line;
            w_wr_data = rf_beat_data;
            w_wr_ben  = 4'hF;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_CLEAR: if (r_clr_line == '1) w_state_next = S_IDLE;
            S_IDLE:  if (rf_start) w_state_next = S_FILL;
            S_FILL:  if (w_beat_acc && r_cnt == OFF'(LINE_WORDS - 1)) w_state_next = S_DONE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= S_RESET;
            r_cnt      <= '0;
            r_line     <= '0;
            r_first    <= '0;
            r_clr_line <= '0;
            rd_valid   <= 1'b0;
            r_data_ok  <= 1'b0;
            r_rd_off   <= '0;
        end else begin
            r_state  <= w_state_next;
            rd_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_data_ok <= 1'b1;
                r_rd_off  <= w_rd_off;
            end
            if (r_state == S_CLEAR) begin
                r_clr_line <= r_clr_line + 1'b1;
            end
            if (r_state == S_IDLE && rf_start) begin
                r_line  <= rf_line;
                r_first <= rf_first;
                r_cnt   <= '0;
            end else if (w_beat_acc) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_bank
        logic [3:0][7:0] r_mem [NUM_LINES];
        logic [31:0]     r_q;
        logic [3:0]      r_byp_ben;
        logic [31:0]     r_byp_data;
        logic [31:0]     w_word;

        assign w_bank_we[gi] = w_clear_wr
                             | (w_st_acc   && (w_st_off   == OFF'(gi)))
                             | (w_beat_acc && (w_beat_off == OFF'(gi)));

        // The read sees the old contents when it hits the word being written
        // in the same cycle. Forwarding is then applied on top of that.
        always_ff @(posedge clk) begin
            for (int b = 0; b < 4; b++) begin
                if (w_bank_we[gi] && w_wr_ben[b]) begin
                    r_mem[w_wr_idx][b] <= w_wr_data[8*b +: 8];
                end
            end
            if (w_rd_acc) begin
                r_q <= r_mem[w_rd_idx];
            end
        end

        // Capture the bytes written in the same cycle as the read was
        // accepted. They are only updated on acceptance, so later writes
        // cannot disturb the data that was returned.
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                r_byp_ben  <= 4'h0;
                r_byp_data <= 32'h0;
            end else if (w_rd_acc) begin
                r_byp_ben  <= (ENABLE_BYPASS && w_bank_we[gi] && (w_wr_idx == w_rd_idx))
                              ? w_wr_ben : 4'h0;
                r_byp_data <= w_wr_data;
            end
        end

        // Until a read completes after reset, the output is forced to zero.
        // This is done because the RAM output register itself is not reset.
        always_comb begin
            w_word = 32'h0;
            if (r_data_ok) begin
                for (int b = 0; b < 4; b++) begin
                    w_word[8*b +: 8] = r_byp_ben[b] ? r_byp_data[8*b +: 8] : r_q[8*b +: 8];
                end
            end
        end

        assign rd_line[32*gi +: 32] = w_word;
    end

    assign rd_data = rd_line[{r_rd_off, 5'd0} +: 32];

endmodule

// File: tb/tb_cache_data_bank.sv
// ---------------------------------------------------------------------------
// tb_cache_data_bank
//
// Three instances run side by side:
//   u_dut     defaults (forwarding on)
//   u_dut_nb  forwarding off; same stimulus as u_dut
//   u_dut_c   zero-fill after reset; own reset and read port, other inputs
//             shared
//
// Read expectations go into a queue when the read is accepted. A monitor
// pops them when rd_valid is seen.
// ---------------------------------------------------------------------------
module tb_cache_data_bank;

    logic         clk = 1'b0;
    logic         resetn, resetn_c;
    logic         rd_req, rd_req_c;
    logic [9:0]   rd_addr, rd_addr_c;
    logic         st_en;
    logic [9:0]   st_addr;
    logic [31:0]  st_data;
    logic [3:0]   st_ben;
    logic         rf_start;
    logic [6:0]   rf_line;
    logic [2:0]   rf_first;
    logic         rf_beat_valid;
    logic [31:0]  rf_beat_data;

    logic         rd_ready, rd_valid, st_ready, rf_beat_ready, rf_done, busy;
    logic [31:0]  rd_data;
    logic [255:0] rd_line;
    logic         rd_ready_b, rd_valid_b, st_ready_b, rf_beat_ready_b, rf_done_b, busy_b;
    logic [31:0]  rd_data_b;
    logic [255:0] rd_line_b;
    logic         rd_ready_c, rd_valid_c, st_ready_c, rf_beat_ready_c, rf_done_c, busy_c;
    logic [31:0]  rd_data_c;
    logic [255:0] rd_line_c;

    always #5 clk = ~clk;

    cache_data_bank u_dut (
        .clk(clk), .resetn(resetn),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_line(rd_line),
        .st_en(st_en), .st_addr(st_addr), .st_data(st_data), .st_ben(st_ben),
        .st_ready(st_ready),
        .rf_start(rf_start), .rf_line(rf_line), .rf_first(rf_first),
        .rf_beat_valid(rf_beat_valid), .rf_beat_data(rf_beat_data),
        .rf_beat_ready(rf_beat_ready), .rf_done(rf_done), .busy(busy)
    );

    cache_data_bank #(.ENABLE_BYPASS(1'b0)) u_dut_nb (
        .clk(clk), .resetn(resetn),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready_b),
        .rd_valid(rd_valid_b), .rd_data(rd_data_b), .rd_line(rd_line_b),
        .st_en(st_en), .st_addr(st_addr), .st_data(st_data), .st_ben(st_ben),
        .st_ready(st_ready_b),
        .rf_start(rf_start), .rf_line(rf_line), .rf_first(rf_first),
        .rf_beat_valid(rf_beat_valid), .rf_beat_data(rf_beat_data),
        .rf_beat_ready(rf_beat_ready_b), .rf_done(rf_done_b), .busy(busy_b)
    );

    cache_data_bank #(.CLEAR_ON_INIT(1'b1)) u_dut_c (
        .clk(clk), .resetn(resetn_c),
        .rd_req(rd_req_c), .rd_addr(rd_addr_c), .rd_ready(rd_ready_c),
        .rd_valid(rd_valid_c), .rd_data(rd_data_c), .rd_line(rd_line_c),
        .st_en(st_en), .st_addr(st_addr), .st_data(st_data), .st_ben(st_ben),
        .st_ready(st_ready_c),
        .rf_start(rf_start), .rf_line(rf_line), .rf_first(rf_first),
        .rf_beat_valid(rf_beat_valid), .rf_beat_data(rf_beat_data),
        .rf_beat_ready(rf_beat_ready_c), .rf_done(rf_done_c), .busy(busy_c)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        string        tag;
        logic [31:0]  d;
        bit           cl;
        logic [255:0] l;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t mon_a;
    exp_t mon_b;

    always @(negedge clk) begin
        if (rd_valid) begin
            if (q_a.size() == 0) begin
                chk("spurious_valid_a", 1, 0);
            end else begin
                mon_a = q_a.pop_front();
                chk({mon_a.tag, "_a"}, rd_data, mon_a.d);
                if (mon_a.cl) chk({mon_a.tag, "_line_a"}, rd_line, mon_a.l);
                $display("read %s bypass=1 data=%h", mon_a.tag, rd_data);
            end
        end
    end

    always @(negedge clk) begin
        if (rd_valid_b) begin
            if (q_b.size() == 0) begin
                chk("spurious_valid_b", 1, 0);
            end else begin
                mon_b = q_b.pop_front();
                chk({mon_b.tag, "_b"}, rd_data_b, mon_b.d);
                if (mon_b.cl) chk({mon_b.tag, "_line_b"}, rd_line_b, mon_b.l);
                $display("read %s bypass=0 data=%h", mon_b.tag, rd_data_b);
            end
        end
    end

    // Ends a cycle: wait for the edge, then drop all strobes.
    task automatic step_end();
        @(posedge clk);
        #1;
        rd_req = 0; rd_req_c = 0; st_en = 0; st_ben = 4'h0;
        rf_start = 0; rf_beat_valid = 0;
    endtask

    // Caller has set rd_req/rd_addr (plus any same-cycle writes).
    task automatic rd_expect(input string tag, input logic [31:0] ea, input logic [31:0] eb,
                             input bit cl, input logic [255:0] l);
        exp_t e;
        @(negedge clk);
        chk({tag, "_rdy"}, rd_ready, 1);
        e.tag = tag; e.d = ea; e.cl = cl; e.l = l;
        if (rd_ready) q_a.push_back(e);
        e.d = eb;
        if (rd_ready_b) q_b.push_back(e);
        step_end();
    endtask

    task automatic rd(input string tag, input logic [9:0] a, input logic [31:0] e);
        rd_req = 1; rd_addr = a;
        rd_expect(tag, e, e, 0, '0);
    endtask

    task automatic st(input logic [9:0] a, input logic [31:0] d, input logic [3:0] ben);
        st_en = 1; st_addr = a; st_data = d; st_ben = ben;
        @(negedge clk);
        chk("st_ready", st_ready, 1);
        $display("store addr=%h data=%h ben=%b", a, d, ben);
        step_end();
    endtask

    task automatic beat(input logic [31:0] d);
        rf_beat_valid = 1; rf_beat_data = d;
        @(negedge clk);
        chk("beat_ready", rf_beat_ready, 1);
        $display("beat data=%h", d);
        step_end();
    endtask

    task automatic clr_read(input logic [9:0] a);
        rd_req_c = 1; rd_addr_c = a;
        @(negedge clk);
        chk("clr_rd_ready", rd_ready_c, 1);
        step_end();
        @(negedge clk);
        chk("clr_rd_valid", rd_valid_c, 1);
        chk("clr_rd_data", rd_data_c, 0);
        chk("clr_rd_line", rd_line_c, 0);
        $display("clear-read addr=%h data=%h", a, rd_data_c);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit seen;
        logic [255:0] line3;

        resetn = 0; resetn_c = 0;
        rd_req = 0; rd_addr = '0; rd_req_c = 0; rd_addr_c = '0;
        st_en = 0; st_addr = '0; st_data = '0; st_ben = '0;
        rf_start = 0; rf_line = '0; rf_first = '0;
        rf_beat_valid = 0; rf_beat_data = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_rd_line", rd_line, 0);
        chk("rst_rf_done", rf_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_busy_c", busy_c, 1);
        resetn = 1; resetn_c = 1;

        // Zero-fill after reset: busy for exactly one cycle per line.
        n = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (!busy_c) break;
            n++;
        end
        chk("clr_busy_cycles", n, 128);
        $display("clear busy cycles=%0d", n);
        @(posedge clk);
        #1;
        clr_read(10'h019);
        clr_read(10'h3FF);

        // Stores and byte enables.
        st(10'h019, 32'h11223344, 4'hF);
        st(10'h020, 32'h44440000, 4'hF);
        st(10'h021, 32'h12345678, 4'hF);
        rd("rd_19_init", 10'h019, 32'h11223344);
        st(10'h019, 32'hAABBCCDD, 4'b0101);
        rd("rd_19_ben0101", 10'h019, 32'h11BB33DD);
        st(10'h019, 32'h00000000, 4'b0000);
        rd("rd_19_ben0000", 10'h019, 32'h11BB33DD);

        // Same-cycle store and read of the same word.
        st_en = 1; st_addr = 10'h019; st_data = 32'hFFFFFFFF; st_ben = 4'hF;
        rd_req = 1; rd_addr = 10'h019;
        rd_expect("rd_19_samecyc", 32'hFFFFFFFF, 32'h11BB33DD, 0, '0);
        rd("rd_19_after", 10'h019, 32'hFFFFFFFF);

        // A write in the cycle after acceptance leaves the returned data alone.
        rd("rd_20", 10'h020, 32'h44440000);
        st_en = 1; st_addr = 10'h020; st_data = 32'h55555555; st_ben = 4'hF;
        step_end();
        @(negedge clk);
        chk("hold_rd_valid", rd_valid, 0);
        chk("hold_rd_data", rd_data, 32'h44440000);
        @(posedge clk);
        #1;
        rd("rd_20_new", 10'h020, 32'h55555555);

        // Refill line 3, critical word 5.
        rf_start = 1; rf_line = 7'd3; rf_first = 3'd5;
        step_end();
        @(negedge clk);
        chk("fill_busy", busy, 1);
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) beat(32'hA0 + k);
        // Stalled beats with probes: blocked read, store and restart.
        rd_req = 1; rd_addr = 10'h01A;
        st_en = 1; st_addr = 10'h021; st_data = 32'h0000DEAD; st_ben = 4'hF;
        rf_start = 1; rf_line = 7'd7; rf_first = 3'd0;
        @(negedge clk);
        chk("fill_rd_ready_l3", rd_ready, 0);
        chk("fill_st_ready", st_ready, 0);
        chk("fill_rf_done", rf_done, 0);
        chk("fill_busy_gap", busy, 1);
        step_end();
        rd("fill_rd_l4", 10'h020, 32'h55555555);
        for (int k = 3; k < 8; k++) beat(32'hA0 + k);
        @(negedge clk);
        chk("done_pulse", rf_done, 1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("done_pulse_end", rf_done, 0);
        chk("done_busy", busy, 0);
        @(posedge clk);
        #1;
        for (int w = 0; w < 8; w++) line3[32*w +: 32] = 32'hA0 + ((w + 3) % 8);
        rd_req = 1; rd_addr = 10'h018;
        rd_expect("rd_l3_w0", 32'hA3, 32'hA3, 1, line3);
        for (int w = 1; w < 8; w++) rd($sformatf("rd_l3_w%0d", w), 10'(24 + w), 32'hA0 + ((w + 3) % 8));
        rd("rd_21_unchanged", 10'h021, 32'h12345678);

        // Reset in the middle of a refill.
        rf_start = 1; rf_line = 7'd6; rf_first = 3'd0;
        step_end();
        for (int k = 0; k < 3; k++) beat(32'hB0 + k);
        resetn = 0;
        @(negedge clk);
        chk("midrst_rf_done", rf_done, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_rd_valid", rd_valid, 0);
        chk("midrst_rd_data", rd_data, 0);
        @(posedge clk);
        #1;
        resetn = 1;
        @(negedge clk);
        chk("midrst_no_done", rf_done, 0);
        @(posedge clk);
        #1;
        rd("rd_l6_w0_kept", 10'h030, 32'hB0);
        rd("rd_l6_w1_kept", 10'h031, 32'hB1);
        rd("rd_l6_w2_kept", 10'h032, 32'hB2);
        rf_start = 1; rf_line = 7'd6; rf_first = 3'd2;
        step_end();
        @(negedge clk);
        chk("restart_busy", busy, 1);
        @(posedge clk);
        #1;
        for (int k = 0; k < 8; k++) beat(32'hC0 + k);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rf_done) begin
                seen = 1;
                break;
            end
        end
        chk("restart_done_seen", seen, 1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rd("rd_l6_w0_new", 10'h030, 32'hC6);
        rd("rd_l6_w2_new", 10'h032, 32'hC0);

        repeat (3) @(posedge clk);
        #1;
        chk("queue_a_empty", q_a.size(), 0);
        chk("queue_b_empty", q_b.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/cache_data_bank.md
CACHE_DATA_BANK -- requirements
Module: cache_data_bank

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, SHALL be the word address width (word = 32 bits).
REQ-002 Parameter LINE_WORDS, default 8, power of two 2..16, SHALL be the words per line; OFF = log2(LINE_WORDS), LINE_IDX_W = ADDR_WIDTH-OFF.
REQ-003 Parameter CLEAR_ON_INIT, default 0, SHALL enable zero-fill of all lines after reset.
REQ-004 Parameter ENABLE_BYPASS, default 1, SHALL enable write-first forwarding into same-cycle reads.
REQ-005 Port list (name direction width meaning), one clock; reset is asynchronous and active-low:
- clk  in  1  sole clock, rising edge
- resetn  in  1  asynchronous active-low reset
- rd_req  in  1  read request, accepted when rd_req & rd_ready
- rd_addr  in  ADDR_WIDTH  word address
- rd_ready  out  1  read may be accepted
- rd_valid  out  1  read data valid
- rd_data  out  32  addressed word
- rd_line  out  32*LINE_WORDS  whole line, word 0 in LSBs
- st_en  in  1  store request, accepted when st_en & st_ready
- st_addr  in  ADDR_WIDTH  store word address
- st_data  in  32  store data
- st_ben  in  4  byte enables, bit i = byte i
- st_ready  out  1  store may be accepted
- rf_start  in  1  begin line refill (honoured only in IDLE)
- rf_line  in  LINE_IDX_W  line index to refill
- rf_first  in  OFF  word offset of first beat (critical word first)
- rf_beat_valid  in  1  refill beat present
- rf_beat_data  in  32  refill beat data
- rf_beat_ready  out  1  beat accepted when rf_beat_valid & rf_beat_ready
- rf_done  out  1  one-cycle pulse: line complete
- busy  out  1  state is not IDLE

Function
REQ-006 Storage SHALL be 2^ADDR_WIDTH words with one write port (byte enables) and one read port, read-port latency exactly 1 cycle.
REQ-007 FSM states SHALL be CLEAR, IDLE, FILL, DONE.
REQ-008 IDLE: rf_start -> FILL, capturing rf_line and rf_first, beat counter cleared to 0; rf_start in any other state SHALL be ignored.
REQ-009 FILL: rf_beat_ready=1; each accepted beat k SHALL write all 4 bytes of word (rf_first+k) mod LINE_WORDS of the captured line (wrap-around); after beat LINE_WORDS-1 -> DONE.
REQ-010 FILL with rf_beat_valid=0 SHALL hold state and counter indefinitely.
REQ-011 DONE: rf_done=1 for exactly one cycle, then -> IDLE.
REQ-012 st_ready SHALL be 1 only in IDLE; an accepted store SHALL write st_data bytes where st_ben=1, others unchanged; st_ben=0 SHALL change nothing.
REQ-013 rd_ready SHALL be 0 in CLEAR, and in FILL/DONE when rd_addr line index equals captured line; 1 otherwise.
REQ-014 An accepted read SHALL assert rd_valid the next cycle with rd_data = word rd_addr and rd_line = its full line; rd_valid=0 otherwise, with rd_data/rd_line holding the last values.
REQ-015 With ENABLE_BYPASS=1, a read accepted in the same cycle as a write (store or beat) to the same line SHALL return post-write contents for the written bytes; with ENABLE_BYPASS=0 such reads SHALL return pre-write contents.
REQ-016 A write in the cycle after read acceptance SHALL NOT alter the returned rd_data/rd_line.
REQ-017 busy SHALL equal (state != IDLE).
REQ-018 Width rule: line index = addr[ADDR_WIDTH-1:OFF], word offset = addr[OFF-1:0]; wrap sum truncated to OFF bits.

Reset
REQ-019 resetn low SHALL asynchronously force rd_valid=0, rd_data=0, rd_line=0, rf_done=0, beat counter=0, captured line/offset=0.
REQ-020 On release, state SHALL be CLEAR if CLEAR_ON_INIT=1, else IDLE; CLEAR SHALL write zero to one line per cycle, lines 0..2^LINE_IDX_W-1, then -> IDLE.
REQ-021 Reset asserted mid-FILL SHALL abandon the refill with no rf_done; words already written SHALL keep their data; RAM is otherwise not reset.

Verification
REQ-022 Defaults: rf_start line 3, rf_first 5, beats 0xA0..0xA7 -> words 5,6,7,0,1,2,3,4 of line 3 get 0xA0..0xA7; rf_done pulses 1 cycle after beat 0xA7.
REQ-023 Word 0x19=0x11223344; store 0xAABBCCDD, st_ben=0101 -> read returns 0x11BB33DD one cycle after acceptance.
REQ-024 Same-cycle store 0xFFFFFFFF ben=1111 and read of word 0x19 -> rd_data 0xFFFFFFFF (bypass=1), old value (bypass=0).
REQ-025 During FILL of line 3: read to line 3 -> rd_ready=0; read to line 4 -> accepted, rd_valid next cycle; st_en -> st_ready=0.
REQ-026 CLEAR_ON_INIT=1: reset release -> busy=1 for exactly 128 cycles, then any read returns 0.
REQ-027 resetn low after 3 beats -> state IDLE/CLEAR, no rf_done, written 3 words retained, new rf_start accepted.
